// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core (lw, sw, beq, j, addi, add/sub/and/or/slt) with one shared
// instruction/data port using a req/ready handshake that tolerates memory wait states.
module mips_multicycle_core #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted
);

    generate
        if (DATA_WIDTH != 32 || ADDR_WIDTH < 8 || ADDR_WIDTH > 32 || RESET_PC[1:0] != 2'b00) begin : g_bad_param
            $error("mips_multicycle_core: unsupported DATA_WIDTH/ADDR_WIDTH/RESET_PC");
        end
    endgenerate

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] ir_q;
    logic [DATA_WIDTH-1:0] mdr_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] alu_out_q;
    logic                  halted_q;
    logic [DATA_WIDTH-1:0] rf_q [0:31];

    // Instruction fields
    logic [5:0]            opcode;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] imm_sl2;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign imm_sl2  = imm_sext << 2;

    logic [DATA_WIDTH-1:0] rs_val;
    logic [DATA_WIDTH-1:0] rt_val;

    assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];

    // ALU for R-type instructions
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  funct_legal;

    always_comb begin
        alu_result  = '0;
        funct_legal = 1'b1;
        case (funct)
            FN_ADD:  alu_result = a_q + b_q;
            FN_SUB:  alu_result = a_q - b_q;
            FN_AND:  alu_result = a_q & b_q;
            FN_OR:   alu_result = a_q | b_q;
            FN_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            default: funct_legal = 1'b0;
        endcase
    end

    state_t decode_next;

    always_comb begin
        decode_next = S_HALT;
        case (opcode)
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_RTYPE:     decode_next = funct_legal ? S_EXEC : S_HALT;
            OP_BEQ:       decode_next = S_BRANCH;
            OP_ADDI:      decode_next = S_ADDIEX;
            OP_J:         decode_next = S_JUMP;
            default:      decode_next = S_HALT;
        endcase
    end

    // Narrow address spaces keep only the low bits of the 32-bit jump target.
    logic [31:0]           pc_ext;
    logic [31:0]           jump_full;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic [ADDR_WIDTH-1:0] pc_plus4;

    assign pc_ext      = 32'(pc_q);
    assign jump_full   = {pc_ext[31:28], ir_q[25:0], 2'b00};
    assign jump_target = jump_full[ADDR_WIDTH-1:0];
    assign pc_plus4    = pc_q + ADDR_WIDTH'(4);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC[ADDR_WIDTH-1:0];
            ir_q      <= '0;
            mdr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        pc_q    <= pc_plus4;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q       <= rs_val;
                    b_q       <= rt_val;
                    alu_out_q <= DATA_WIDTH'(pc_q) + imm_sl2;
                    state_q   <= decode_next;
                    if (decode_next == S_HALT) begin
                        halted_q <= 1'b1;
                    end
                end
                S_MEMADR: begin
                    alu_out_q <= a_q + imm_sext;
                    state_q   <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        mdr_q   <= mem_rdata;
                        state_q <= S_MEMWB;
                    end
                end
                S_MEMWB: state_q <= S_FETCH;
                S_MEMWR: begin
                    if (mem_ready) begin
                        state_q <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    alu_out_q <= alu_result;
                    state_q   <= S_ALUWB;
                end
                S_ALUWB: state_q <= S_FETCH;
                S_ADDIEX: begin
                    alu_out_q <= a_q + imm_sext;
                    state_q   <= S_ADDIWB;
                end
                S_ADDIWB: state_q <= S_FETCH;
                S_BRANCH: begin
                    if (a_q == b_q) begin
                        pc_q <= alu_out_q[ADDR_WIDTH-1:0];
                    end
                    state_q <= S_FETCH;
                end
                S_JUMP: begin
                    pc_q    <= jump_target;
                    state_q <= S_FETCH;
                end
                S_HALT: halted_q <= 1'b1;
                default: begin
                    state_q  <= S_HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    // Register file write-back; r0 is never written.
    logic                  rf_we_d;
    logic [4:0]            rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_d;

    assign rf_we_d    = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_ADDIWB);
    assign rf_waddr_d = (state_q == S_ALUWB) ? rd : rt;
    assign rf_wdata_d = (state_q == S_MEMWB) ? mdr_q : alu_out_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we_d && rf_waddr_d != 5'd0) begin
            rf_q[rf_waddr_d] <= rf_wdata_d;
        end
    end

    // Request is gated by RST so a pending access is dropped the instant reset asserts
    // and the first fetch is presented in the very cycle reset is released.
    logic req_state;

    assign req_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign mem_req   = RST & req_state;
    assign mem_we    = mem_req & (state_q == S_MEMWR);
    assign mem_addr  = !mem_req ? '0 :
                       (state_q == S_FETCH) ? pc_q : alu_out_q[ADDR_WIDTH-1:0];
    assign mem_wdata = mem_we ? b_q : '0;
    assign pc        = pc_q;
    assign halted    = halted_q;

    logic unused_bits;
    assign unused_bits = ^{ir_q[10:6], pc_ext, jump_full};

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: a wait-state memory model, a write
// scoreboard, fetch-timing log and reset/halt checks.
module tb_mips_multicycle_core;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
    logic [AW-1:0] dut_pc;
    logic          halted;

    mips_multicycle_core #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (32'h0000_0040),
        .DATA_WIDTH(32)
    ) dut (
        .CLK      (clk),
        .RST      (rst_n),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc       (dut_pc),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word array, separate wait counts for reads and writes
    logic [31:0] mem [0:511];
    logic        ld_we = 1'b0;
    logic [8:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;
    int          rd_waits = 0;
    int          wr_waits = 0;
    int          wait_cnt = 0;

    assign mem_ready = (wait_cnt >= (mem_we ? wr_waits : rd_waits));
    assign mem_rdata = mem[mem_addr[10:2]];

    always @(posedge clk) begin
        if (ld_we) mem[ld_idx] <= ld_data;
        else if (mem_req && mem_ready && mem_we) mem[mem_addr[10:2]] <= mem_wdata;
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [31:0] addr; int cyc; } fetch_t;
    wr_t    exp_q[$];
    fetch_t fetch_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_fetch(input logic [31:0] addr);
        int n = 0;
        foreach (fetch_log[i]) if (fetch_log[i].addr == addr) n++;
        return n;
    endfunction

    function automatic int find_fetch(input logic [31:0] addr, input int nth);
        int n = 0;
        foreach (fetch_log[i]) begin
            if (fetch_log[i].addr == addr) begin
                if (n == nth) return fetch_log[i].cyc;
                n++;
            end
        end
        return -1000;
    endfunction

    // Monitor: logs fetch starts and scores completed writes against the queue
    initial begin : monitor
        logic prev_fetch;
        logic cur_fetch;
        wr_t  e;
        prev_fetch = 1'b0;
        forever begin
            @(negedge clk);
            cur_fetch = mem_req && !mem_we && (mem_addr == dut_pc);
            if (cur_fetch && !prev_fetch) fetch_log.push_back('{32'(mem_addr), cyc});
            prev_fetch = cur_fetch;
            if (mem_req && mem_we && mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_write", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_addr", 32'(mem_addr), e.addr);
                    check("sb_data", mem_wdata, e.data);
                end
            end
        end
    end

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_idx  = addr[10:2];
        ld_data = data;
        @(posedge clk);
        #1;
        ld_we = 1'b0;
    endtask

    task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back('{addr, data});
    endtask

    task automatic wait_fetches(input logic [31:0] addr, input int n, input int budget, input string tag);
        int k = 0;
        while (count_fetch(addr) < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(tag, 32'(count_fetch(addr)), 32'(n));
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        int reqs;
        // ---------------- Phase 1: ALU, memory, branches, jump (no waits)
        load(32'h40, enc_i(6'h08, 0, 1, 16'd5));       // addi r1,r0,5
        load(32'h44, enc_i(6'h08, 0, 2, 16'hFFFD));    // addi r2,r0,-3
        load(32'h48, enc_r(1, 2, 3, 6'h20));           // add  r3,r1,r2
        load(32'h4C, enc_r(2, 1, 4, 6'h2A));           // slt  r4,r2,r1
        load(32'h50, enc_r(1, 2, 6, 6'h22));           // sub  r6,r1,r2
        load(32'h54, enc_r(1, 2, 7, 6'h24));           // and  r7,r1,r2
        load(32'h58, enc_r(1, 2, 8, 6'h25));           // or   r8,r1,r2
        load(32'h5C, enc_r(1, 2, 9, 6'h2A));           // slt  r9,r1,r2
        load(32'h60, enc_i(6'h2B, 0, 3, 16'd8));
        load(32'h64, enc_i(6'h2B, 0, 4, 16'd12));
        load(32'h68, enc_i(6'h2B, 0, 6, 16'd16));
        load(32'h6C, enc_i(6'h2B, 0, 7, 16'd20));
        load(32'h70, enc_i(6'h2B, 0, 8, 16'd24));
        load(32'h74, enc_i(6'h2B, 0, 9, 16'd28));
        load(32'h78, enc_i(6'h08, 0, 0, 16'd7));       // addi r0,r0,7 (discarded)
        load(32'h7C, enc_i(6'h2B, 0, 0, 16'd32));
        load(32'h80, enc_i(6'h23, 0, 5, 16'd8));       // lw r5,8(r0)
        load(32'h84, enc_i(6'h2B, 0, 5, 16'd36));
        load(32'h88, enc_i(6'h04, 1, 2, 16'd5));       // beq not taken
        load(32'h8C, enc_i(6'h04, 0, 0, 16'd1));       // beq taken, skips 0x90
        load(32'h90, enc_i(6'h2B, 0, 1, 16'd40));
        load(32'h94, {6'h02, 26'h100});                // j 0x400
        load(32'h400, enc_i(6'h2B, 0, 1, 16'd44));
        load(32'h404, enc_i(6'h04, 0, 0, 16'hFFFF));   // beq r0,r0,-1
        expect_wr(32'd8, 32'd2);
        expect_wr(32'd12, 32'd1);
        expect_wr(32'd16, 32'd8);
        expect_wr(32'd20, 32'd5);
        expect_wr(32'd24, 32'hFFFF_FFFD);
        expect_wr(32'd28, 32'd0);
        expect_wr(32'd32, 32'd0);
        expect_wr(32'd36, 32'd2);
        expect_wr(32'd44, 32'd5);

        @(negedge clk);
        check("rst_pc", 32'(dut_pc), 32'h40);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("first_req", 32'(mem_req), 32'd1);
        check("first_we", 32'(mem_we), 32'd0);
        check("first_addr", 32'(mem_addr), 32'h40);
        @(posedge clk);
        #1;
        check("pc_after_fetch", 32'(dut_pc), 32'h44);

        wait_fetches(32'h404, 3, 400, "p1_reach_loop");
        check("t_addi1", 32'(find_fetch(32'h44, 0) - find_fetch(32'h40, 0)), 32'd4);
        check("t_addi2", 32'(find_fetch(32'h48, 0) - find_fetch(32'h44, 0)), 32'd4);
        check("t_add", 32'(find_fetch(32'h4C, 0) - find_fetch(32'h48, 0)), 32'd4);
        check("t_slt", 32'(find_fetch(32'h50, 0) - find_fetch(32'h4C, 0)), 32'd4);
        check("t_sw", 32'(find_fetch(32'h64, 0) - find_fetch(32'h60, 0)), 32'd4);
        check("t_lw", 32'(find_fetch(32'h84, 0) - find_fetch(32'h80, 0)), 32'd5);
        check("t_beq_nt", 32'(find_fetch(32'h8C, 0) - find_fetch(32'h88, 0)), 32'd3);
        check("t_beq_tk", 32'(find_fetch(32'h94, 0) - find_fetch(32'h8C, 0)), 32'd3);
        check("t_jump", 32'(find_fetch(32'h400, 0) - find_fetch(32'h94, 0)), 32'd3);
        check("t_loop", 32'(find_fetch(32'h404, 1) - find_fetch(32'h404, 0)), 32'd3);
        check("skip_0x90", 32'(count_fetch(32'h90)), 32'd0);
        check("p1_sb_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- Phase 2: store/load with 2 wait cycles per request
        @(negedge clk);
        rst_n = 1'b0;
        rd_waits = 2;
        wr_waits = 2;
        load(32'h40, enc_i(6'h08, 0, 3, 16'd2));       // addi r3,r0,2
        load(32'h44, enc_i(6'h2B, 0, 3, 16'd48));      // sw r3,48(r0)
        load(32'h48, enc_i(6'h23, 0, 5, 16'd48));      // lw r5,48(r0)
        load(32'h4C, enc_i(6'h2B, 0, 5, 16'd52));      // sw r5,52(r0)
        load(32'h50, enc_i(6'h04, 0, 0, 16'hFFFF));
        expect_wr(32'd48, 32'd2);
        expect_wr(32'd52, 32'd2);
        fetch_log.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
        @(negedge clk);
        while (!(mem_req && mem_we) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("p2_sw_seen", 32'(mem_we), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("p2_hold_req", 32'(mem_req), 32'd1);
            check("p2_hold_addr", 32'(mem_addr), 32'd48);
            check("p2_hold_wdata", mem_wdata, 32'd2);
            @(negedge clk);
        end
        check("p2_we_after_write", 32'(mem_we), 32'd0);
        wait_fetches(32'h50, 2, 300, "p2_reach_loop");
        check("t_sw_wait", 32'(find_fetch(32'h48, 0) - find_fetch(32'h44, 0)), 32'd8);
        check("t_lw_wait", 32'(find_fetch(32'h4C, 0) - find_fetch(32'h48, 0)), 32'd9);
        check("p2_sb_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- Phase 3: illegal opcode, then illegal funct
        @(negedge clk);
        rst_n = 1'b0;
        rd_waits = 0;
        wr_waits = 0;
        load(32'h40, enc_i(6'h08, 0, 1, 16'd1));
        load(32'h44, 32'hFC00_0000);                   // opcode 0x3F
        fetch_log.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_fetches(32'h44, 1, 50, "p3_fetch_illegal");
        @(negedge clk);
        check("p3_halted_in_decode", 32'(halted), 32'd0);
        @(negedge clk);
        check("p3_halted", 32'(halted), 32'd1);
        check("p3_pc_frozen", 32'(dut_pc), 32'h48);
        reqs = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_req) reqs++;
        end
        check("p3_no_req_20", 32'(reqs), 32'd0);
        check("p3_pc_still", 32'(dut_pc), 32'h48);
        check("p3_halted_sticky", 32'(halted), 32'd1);
        rst_n = 1'b0;
        #1;
        check("p3_rst_halted", 32'(halted), 32'd0);
        check("p3_rst_pc", 32'(dut_pc), 32'h40);
        load(32'h40, enc_r(1, 2, 3, 6'h21));           // unsupported funct
        fetch_log.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_fetches(32'h40, 1, 50, "p3_fetch_badfn");
        @(negedge clk);
        check("p3_fn_decode", 32'(halted), 32'd0);
        @(negedge clk);
        check("p3_fn_halted", 32'(halted), 32'd1);
        check("p3_fn_pc", 32'(dut_pc), 32'h44);

        // ---------------- Phase 4: reset while a store is waiting
        @(negedge clk);
        rst_n = 1'b0;
        wr_waits = 1000;
        load(32'h40, enc_i(6'h08, 0, 1, 16'd9));
        load(32'h44, enc_i(6'h2B, 0, 1, 16'd56));
        load(32'h48, enc_i(6'h04, 0, 0, 16'hFFFF));
        load(32'd56, 32'hDEAD_BEEF);
        fetch_log.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
        @(negedge clk);
        while (!(mem_req && mem_we) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("p4_sw_seen", 32'(mem_we), 32'd1);
        repeat (3) @(negedge clk);
        check("p4_sw_pending", 32'(mem_we), 32'd1);
        check("p4_sw_addr", 32'(mem_addr), 32'd56);
        rst_n = 1'b0;
        #1;
        check("p4_abandon_req", 32'(mem_req), 32'd0);
        check("p4_abandon_we", 32'(mem_we), 32'd0);
        check("p4_abandon_addr", 32'(mem_addr), 32'd0);
        check("p4_abandon_pc", 32'(dut_pc), 32'h40);
        repeat (2) @(posedge clk);
        #1;
        check("p4_mem_untouched", mem[14], 32'hDEAD_BEEF);
        wr_waits = 0;
        expect_wr(32'd56, 32'd9);
        fetch_log.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("p4_restart_req", 32'(mem_req), 32'd1);
        check("p4_restart_we", 32'(mem_we), 32'd0);
        check("p4_restart_addr", 32'(mem_addr), 32'h40);
        wait_fetches(32'h48, 2, 100, "p4_reach_loop");
        check("p4_mem_written", mem[14], 32'd9);
        check("p4_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
